// File: rtl/layer_mac_seq.sv
// Fully connected layer sequencer: buffers one activation vector, walks the weight ROM
// neuron by neuron, and streams one shifted/ReLU/saturated byte per neuron.
module layer_mac_seq #(
  parameter int unsigned N_IN  = 6,
  parameter int unsigned N_OUT = 13,
  parameter int unsigned WBASE = 0,
  parameter int unsigned FRAC  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [7:0] w_addr,
  input  logic [7:0] w_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy
);

  localparam int unsigned D_W   = 8;
  localparam int unsigned A_W   = 8;
  localparam int unsigned P_W   = 16;
  localparam int unsigned ACC_W = 20;
  localparam int unsigned K_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned J_W   = $clog2(N_IN + 1);
  localparam int unsigned N_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_OUT
  } state_t;

  state_t state, state_next;

  logic [K_W-1:0]          k, k_d;
  logic [J_W-1:0]          j, j_d;
  logic [N_W-1:0]          n, n_d;
  logic signed [ACC_W-1:0] acc, acc_d;
  logic [A_W-1:0]          w_addr_d;
  logic [D_W-1:0]          out_data_d;
  logic                    out_last_d;
  logic                    out_valid_d;
  logic                    in_ready_d;
  logic                    busy_d;
  logic                    x_we;

  logic signed [D_W-1:0]   x [N_IN];
  logic signed [D_W-1:0]   x_sel;
  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] scaled;
  logic [D_W-1:0]          result;

  logic in_fire, out_fire, k_last, j_bias, n_last;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign k_last   = (k == K_W'(N_IN - 1));
  assign j_bias   = (j == J_W'(N_IN));
  assign n_last   = (n == N_W'(N_OUT - 1));

  // Activation select for the current weight index
  always_comb begin
    x_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (j == J_W'(i)) x_sel = x[i];
    end
  end

  assign prod   = P_W'($signed(w_data)) * P_W'(x_sel);
  assign sum    = acc + (ACC_W'($signed(w_data)) <<< FRAC);
  assign scaled = sum >>> FRAC;

  // ReLU then clamp to the 7-bit positive range
  always_comb begin
    if (scaled < 0)
      result = '0;
    else if (scaled > ACC_W'(127))
      result = D_W'(127);
    else
      result = scaled[D_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD:  if (in_fire && k_last) state_next = S_RUN;
      S_RUN:   if (j_bias) state_next = S_OUT;
      S_OUT:   if (out_fire) state_next = n_last ? S_LOAD : S_RUN;
      default: state_next = S_LOAD;
    endcase
  end

  // Next values of counters, accumulator and registered outputs
  always_comb begin
    k_d        = k;
    j_d        = j;
    n_d        = n;
    acc_d      = acc;
    w_addr_d   = w_addr;
    out_data_d = out_data;
    out_last_d = out_last;
    x_we       = 1'b0;
    case (state)
      S_LOAD: begin
        if (in_fire) begin
          x_we = 1'b1;
          if (k_last) begin
            k_d      = '0;
            j_d      = '0;
            n_d      = '0;
            acc_d    = '0;
            w_addr_d = A_W'(WBASE);
          end else begin
            k_d = K_W'(k + 1'b1);
          end
        end
      end
      S_RUN: begin
        if (j_bias) begin
          out_data_d = result;
          out_last_d = n_last;
        end else begin
          acc_d    = acc + ACC_W'(prod);
          j_d      = J_W'(j + 1'b1);
          w_addr_d = A_W'(w_addr + 1'b1);
        end
      end
      S_OUT: begin
        if (out_fire) begin
          j_d   = '0;
          acc_d = '0;
          if (n_last) begin
            n_d        = '0;
            k_d        = '0;
            out_last_d = 1'b0;
            w_addr_d   = A_W'(WBASE);
          end else begin
            n_d      = N_W'(n + 1'b1);
            w_addr_d = A_W'(w_addr + 1'b1);
          end
        end
      end
      default: ;
    endcase
    in_ready_d  = (state_next == S_LOAD);
    busy_d      = (state_next != S_LOAD);
    out_valid_d = (state_next == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k         <= '0;
      j         <= '0;
      n         <= '0;
      acc       <= '0;
      w_addr    <= A_W'(WBASE);
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      k         <= k_d;
      j         <= j_d;
      n         <= n_d;
      acc       <= acc_d;
      w_addr    <= w_addr_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
    end
  end

  // Activation buffer keeps its contents across reset
  always_ff @(posedge clk) begin
    if (x_we) x[k] <= $signed(in_data);
  end

endmodule

// File: tb/tb_layer_mac_seq.sv
// Directed bench for layer_mac_seq with a falling-edge registered weight ROM model.
module tb_layer_mac_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] w_addr;
  logic [7:0] w_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] res_q[$];
  logic       last_q[$];
  logic [7:0] addr_q[$];

  layer_mac_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Neuron 0: weights sum 183, bias 31. Neuron 1: weights sum -50, bias 41.
  function automatic int rom_val(input int a);
    case (a)
      0: return 30;   1: return 31;   2: return 32;  3: return 30;
      4: return 30;   5: return 30;   6: return 31;
      7: return -10;  8: return -8;   9: return -9;  10: return -7;
      11: return -6;  12: return -10; 13: return 41;
      default: return ((a * 37 + 11) % 256) - 128;
    endcase
  endfunction

  function automatic int model(input int nn, input int xv);
    int s;
    s = rom_val(nn * 7 + 6) * 32;
    for (int q = 0; q < 6; q++) s += rom_val(nn * 7 + q) * xv;
    s = s >>> 5;
    if (s < 0) return 0;
    if (s > 127) return 127;
    return s;
  endfunction

  always @(negedge clk) w_data <= 8'(rom_val(int'(w_addr)));

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      res_q.push_back(out_data);
      last_q.push_back(out_last);
    end
    if (busy && !out_valid) addr_q.push_back(w_addr);
  end

  task automatic clear_q();
    res_q.delete();
    last_q.delete();
    addr_q.delete();
  endtask

  task automatic load_vec(input logic [7:0] v);
    int beats = 0;
    int guard = 0;
    logic rdy;
    while (beats < 6 && guard < 60) begin
      in_valid = 1'b1;
      in_data  = v;
      rdy      = in_ready;
      @(posedge clk); #1;
      if (rdy) beats++;
      guard++;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    checks++;
    if (beats !== 6) begin
      errors++;
      $display("FAIL load_beats got %0d want 6", beats);
    end
  endtask

  task automatic wait_results(input int want, output int cycles);
    cycles = 0;
    while (res_q.size() < want && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
      if (res_q.size() >= want - 1) in_valid = 1'b0;
    end
    checks++;
    if (res_q.size() !== want) begin
      errors++;
      $display("FAIL result_count got %0d want %0d", res_q.size(), want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %0d want 0", out_data); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (w_addr !== 8'h00) begin errors++; $display("FAIL rst_w_addr got %0d want 0", w_addr); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    rst = 1'b0;
  endtask

  // Full layer for one constant vector; junk on in_valid during RUN must be ignored
  task automatic test_vector(input string tag, input logic [7:0] v, input int exp0, input int exp1);
    int cyc;
    int xv;
    xv = int'($signed(v));
    clear_q();
    out_ready = 1'b1;
    load_vec(v);
    in_valid = 1'b1;
    in_data  = 8'h55;
    wait_results(13, cyc);
    checks += 3;
    if (cyc !== 104) begin errors++; $display("FAIL %s layer_cycles got %0d want 104", tag, cyc); end
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s idle_after_layer got ready=%b busy=%b want 1/0", tag, in_ready, busy);
    end
    if (res_q.size() > 0 && int'(res_q[0]) !== exp0) begin
      errors++; $display("FAIL %s neuron0 got %0d want %0d", tag, res_q[0], exp0);
    end
    if (exp1 >= 0 && res_q.size() > 1) begin
      checks++;
      if (int'(res_q[1]) !== exp1) begin errors++; $display("FAIL %s neuron1 got %0d want %0d", tag, res_q[1], exp1); end
    end
    for (int i = 0; i < res_q.size(); i++) begin
      checks += 2;
      if (int'(res_q[i]) !== model(i, xv)) begin
        errors++; $display("FAIL %s result[%0d] got %0d want %0d", tag, i, res_q[i], model(i, xv));
      end
      if (last_q[i] !== (i == 12)) begin
        errors++; $display("FAIL %s out_last[%0d] got %b want %b", tag, i, last_q[i], (i == 12));
      end
    end
    checks++;
    if (addr_q.size() !== 91) begin
      errors++; $display("FAIL %s addr_count got %0d want 91", tag, addr_q.size());
    end else begin
      for (int i = 0; i < 91; i++) begin
        checks++;
        if (int'(addr_q[i]) !== i) begin errors++; $display("FAIL %s addr[%0d] got %0d want %0d", tag, i, addr_q[i], i); end
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int guard;
    logic [7:0] want;
    clear_q();
    out_ready = 1'b1;
    load_vec(8'h01);
    wait_results(2, cyc);
    out_ready = 1'b0;
    guard = 0;
    while (!out_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    want = 8'(model(2, 1));
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_rise got %b want 1", out_valid); end
    if (out_data !== want) begin errors++; $display("FAIL bp_data got %0d want %0d", out_data, want); end
    if (w_addr !== 8'd20) begin errors++; $display("FAIL bp_addr got %0d want 20", w_addr); end
    repeat (5) begin
      @(posedge clk); #1;
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b want 1", out_valid); end
      if (out_data !== want) begin errors++; $display("FAIL bp_hold_data got %0d want %0d", out_data, want); end
      if (w_addr !== 8'd20) begin errors++; $display("FAIL bp_hold_addr got %0d want 20", w_addr); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    if (w_addr !== 8'd21) begin errors++; $display("FAIL bp_resume_addr got %0d want 21", w_addr); end
    if (res_q.size() !== 3) begin errors++; $display("FAIL bp_one_accept got %0d want 3", res_q.size()); end
    wait_results(13, cyc);
    for (int i = 0; i < res_q.size(); i++) begin
      checks++;
      if (int'(res_q[i]) !== model(i, 1)) begin
        errors++; $display("FAIL bp_result[%0d] got %0d want %0d", i, res_q[i], model(i, 1));
      end
    end
    checks++;
    if (addr_q.size() !== 91 || addr_q[90] !== 8'd90) begin
      errors++; $display("FAIL bp_addr_seq got count %0d want 91", addr_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    clear_q();
    out_ready = 1'b1;
    load_vec(8'h01);
    wait_results(4, cyc);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (w_addr !== 8'd31) begin errors++; $display("FAIL mr_pre_addr got %0d want 31", w_addr); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks += 4;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mr_in_ready got %b want 1", in_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy got %b want 0", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_out_valid got %b want 0", out_valid); end
    if (w_addr !== 8'h00) begin errors++; $display("FAIL mr_w_addr got %0d want 0", w_addr); end
    repeat (8) begin @(posedge clk); #1; end
    checks++;
    if (res_q.size() !== 4) begin errors++; $display("FAIL mr_no_output got %0d want 4", res_q.size()); end
    load_vec(8'h01);
    wait_results(5, cyc);
    checks++;
    if (res_q.size() > 4 && res_q[4] !== 8'd36) begin
      errors++; $display("FAIL mr_reload_neuron0 got %0d want 36", res_q[4]);
    end
    wait_results(17, cyc);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    test_reset();
    test_vector("ones", 8'h01, 36, 39);
    test_vector("zeros", 8'h00, 31, 41);
    test_vector("sat", 8'h7F, 127, -1);
    test_vector("relu", 8'h80, 0, -1);
    test_backpressure();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
